gold_code_rx: RTL and testbench
===============================

Name: gold_code_rx

Overview:
- Receiver end of the Gold-code link. Takes the serial Gold chip stream and the period-start strobe produced by the Gold generator.
- Recovers the code shift that the generator applied to its second m-sequence, then checks every remaining chip of the period against the regenerated code.
- Reports one result per code period on an AXI-Stream master: shift, chip error count and flags. The result feeds the same stream infrastructure that carries shift values to the generator.

Parameters:
- N, 5, LFSR degree; legal range 3..8; code length L = 2^N-1.
- POLY1, 5'b00101, tap mask of m-sequence 1 (N bits).
- POLY2, 5'b01111, tap mask of m-sequence 2 (N bits).
- INIT1, 5'b00001, m1 state at period start; nonzero.
- INIT2, 5'b00001, m2 reference state at shift 0; nonzero.

Ports:
- clkin  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- chip_i  in  1  received Gold chip; sampled when chip_vld_i=1.
- chip_vld_i  in  1  chip qualifier; at most one chip per clock.
- sof_i  in  1  period start; qualified by chip_vld_i and coincident with chip 0.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  16  [7:0] shift k, [13:8] error count, [14] no_match, [15] overrun.
- m_axis_tlast  out  1  constant 1; every result is a one-beat packet.

Behaviour:
- LFSR convention, used by both LFSRs and the reference generator:
  - out = s[0]; fb = ^(s & POLY); next = {fb, s[N-1:1]}.
  - Gold chip = m1.out XOR m2.out.
  - Shift k means m2 starts at INIT2 advanced k steps.
- Reset: m_axis_tvalid=0, m_axis_tdata=0, all state cleared, FSM=IDLE. Reset mid-period discards the partial period with no output.
- FSM states:
  - IDLE: wait for sof_i&chip_vld_i. Chips without a preceding sof are ignored.
  - CAPTURE: on sof, load m1=INIT1 and chip index c=0. For c=0..N-1, d_c = chip_i XOR m1.out and cap[c]=d_c; step m1 on each valid chip. After chip N-1, go to TRACK.
  - TRACK: two activities run concurrently.
    - Verify: load pred=cap, then advance pred N steps before the first comparison so that it is aligned to chip N. For chips c=N..L-1, compare chip_i against m1.out XOR pred.out and increment err on mismatch; err saturates at 63. Step m1 and pred on each valid chip.
    - Search: starts the cycle after capture completes. ref=INIT2, k=0. Each clock: if ref==cap, latch shift=k and set done; else step ref and k++. If k reaches L with no match, set no_match=1, shift=0, done.
    - If cap==0, set no_match immediately.
    - Search finishes within L clocks, independent of chip timing.
  - RESULT: entered when chip L-1 has been processed and search is done. Both conditions may complete in either order or in the same cycle. Load the output register, assert m_axis_tvalid, return to IDLE. The receiver then accepts the next sof immediately, including one in the cycle right after chip L-1.
- Handshake:
  - tdata is held stable while tvalid=1 and tready=0.
  - The beat transfers on tvalid&tready; tvalid drops the following cycle unless a new result loads in that same cycle.
  - A new result arriving while tvalid=1 and tready=0 is dropped; bit[15] overrun is set sticky in the held word and clears on transfer.
  - Load and transfer in the same cycle: the new result replaces the old one, with no overrun.
- sof_i during CAPTURE or TRACK (c≠L): abort the current period with no output and restart CAPTURE from this chip.
- sof_i together with chip c=L-1 semantics does not occur; an sof there is treated as an abort.
- Chip gaps are arbitrary. Search runs on clkin and does not wait for chips.
- Latency: from the last chip of a period to tvalid is max(1, remaining search clocks + 1).

Test Plan:
- Shift 0, clean stream, chip_vld_i=1 continuously, tready=1 -> one beat, tdata=16'h0000, tlast=1.
- Shift 17, chip_vld_i asserted every 3rd clock -> tdata[7:0]=17, err=0, flags=0. Repeat for every k in 0..30; each result is correct.
- Shift 9 with chips 10 and 20 inverted -> shift=9, err=2. Additionally invert chip 2, which lies in the capture window -> the shift is wrong or no_match is set, and err is nonzero.
- Stream equal to m1 alone (captured state 0) -> no_match=1, shift=0.
- tready=0 across two full periods (shifts 4, then 5) -> tdata holds shift 4 with bit15=1. Raise tready -> one transfer, then tvalid=0.
- sof reasserted at chip 12, then a clean shift-6 period -> exactly one beat, shift=6. rstn pulsed low mid-TRACK -> no beat, and tvalid=0 at once.

Source files
------------

// File: rtl/gold_code_rx.sv
// gold_code_rx
//   Receiver for the Gold-code link. For each code period it does two things:
//   it recovers the shift that the generator applied to its second m-sequence,
//   and it counts chip errors in the rest of the period by checking it against
//   the regenerated code. It then emits one AXI-Stream beat per period.
//
//   Ports
//     clkin          clock
//     rstn           asynchronous active-low reset
//     chip_i         received Gold chip, sampled when chip_vld_i=1
//     chip_vld_i     chip qualifier, at most one chip per clock
//     sof_i          period start, qualified by chip_vld_i, coincides with chip 0
//     m_axis_tvalid  result valid
//     m_axis_tready  downstream ready
//     m_axis_tdata   [7:0] shift, [13:8] error count, [14] no_match, [15] overrun
//     m_axis_tlast   always 1 (every result is a one-beat packet)
//
//   Recovery principle
//     With next = {fb, s[N-1:1]} and out = s[0], the first N outputs of an LFSR
//     are exactly the bits of its starting state. So if we XOR the first N
//     received chips with m1, we get the m2 state at chip 0 (cap). A search then
//     walks a reference m2 from INIT2 until it equals cap; the step count is
//     the shift. Meanwhile a copy of cap is advanced N steps and run alongside
//     m1 to predict chips N..L-1.
module gold_code_rx #(
    parameter int unsigned    N     = 5,        // LFSR degree, 3..8
    parameter logic [N-1:0]   POLY1 = 5'b00101, // m1 tap mask
    parameter logic [N-1:0]   POLY2 = 5'b01111, // m2 tap mask
    parameter logic [N-1:0]   INIT1 = 5'b00001, // m1 state at chip 0
    parameter logic [N-1:0]   INIT2 = 5'b00001  // m2 state at shift 0
) (
    input  logic        clkin,
    input  logic        rstn,
    input  logic        chip_i,
    input  logic        chip_vld_i,
    input  logic        sof_i,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tlast
);

    localparam int unsigned L = (1 << N) - 1;

    // Chip index c is N bits wide. Its all-ones value (== L) marks
    // "every chip of the period has been processed".
    localparam logic [N-1:0] C_CAP_END = N'(N - 1);
    localparam logic [N-1:0] C_LAST    = N'(L - 1);
    localparam logic [N-1:0] C_END     = N'(L);
    localparam logic [5:0]   ERR_MAX   = 6'd63;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        TRACK
    } state_t;

    function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s,
                                               input logic [N-1:0] p);
        return {^(s & p), s[N-1:1]};
    endfunction

    function automatic logic [N-1:0] lfsr_adv_n(input logic [N-1:0] s,
                                                input logic [N-1:0] p);
        logic [N-1:0] t;
        t = s;
        for (int i = 0; i < int'(N); i++) t = lfsr_step(t, p);
        return t;
    endfunction

    state_t       state;
    logic [N-1:0] c;          // chip index within the period
    logic [N-1:0] m1;         // local m1, aligned to chip c
    logic [N-1:0] cap;        // captured m2 state at chip 0
    logic [N-1:0] pred;       // predicted m2, aligned to chip c in TRACK
    logic [N-1:0] ref_s;      // search reference m2 state
    logic [N-1:0] k;          // search step count
    logic [N-1:0] shift_r;    // latched search result
    logic         nm_r;       // latched no_match
    logic         sdone;      // search finished
    logic [5:0]   err;        // saturating chip error count

    // ------------------------------------------------------------------
    // Period control
    // ------------------------------------------------------------------
    logic sof_go;
    logic [N-1:0] cap_sof, cap_shift;

    // sof aborts and restarts from any state except the drain phase
    // (all chips processed, search still running). There the period is
    // already complete, so a stray sof is ignored like an unframed chip.
    assign sof_go    = sof_i & chip_vld_i & ~(state == TRACK && c == C_END);
    assign cap_sof   = {chip_i ^ INIT1[0], cap[N-1:1]};
    assign cap_shift = {chip_i ^ m1[0],    cap[N-1:1]};

    // ------------------------------------------------------------------
    // Search: one comparison per clock, independent of chip timing
    // ------------------------------------------------------------------
    logic         s_match, s_zero, s_fin;
    logic [N-1:0] s_shift_now;
    logic         s_nm_now;

    assign s_match = (ref_s == cap);
    assign s_zero  = (cap == '0);
    // A zero capture cannot be a valid m2 state, so it finishes at once.
    // If the last candidate (k = L-1) misses, the search ends with no match.
    assign s_fin   = sdone | s_zero | s_match | (k == C_LAST);

    always_comb begin
        s_shift_now = '0;
        s_nm_now    = 1'b0;
        if (sdone) begin
            s_shift_now = shift_r;
            s_nm_now    = nm_r;
        end else if (!s_zero && s_match) begin
            s_shift_now = k;
        end else begin
            s_nm_now    = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Verify: chips N..L-1 against m1 ^ pred
    // ------------------------------------------------------------------
    logic       trk_chip, mism, chips_fin, finish;
    logic [5:0] err_now;

    assign trk_chip  = (state == TRACK) & chip_vld_i & ~sof_go & (c != C_END);
    assign mism      = chip_i ^ m1[0] ^ pred[0];
    assign err_now   = err + 6'((trk_chip & mism & (err != ERR_MAX)) ? 1 : 0);
    assign chips_fin = (c == C_END) | (trk_chip & (c == C_LAST));

    // The result is produced on the edge where the last chip and the search
    // have both completed, whichever order they finish in. The FSM goes back
    // to IDLE on that same edge, so an sof in the very next cycle is accepted.
    assign finish    = (state == TRACK) & ~sof_go & chips_fin & s_fin;

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            c       <= '0;
            m1      <= '0;
            cap     <= '0;
            pred    <= '0;
            ref_s   <= '0;
            k       <= '0;
            shift_r <= '0;
            nm_r    <= 1'b0;
            sdone   <= 1'b0;
            err     <= '0;
        end else if (sof_go) begin
            // Chip 0 of a new period (also covers an abort mid-period).
            state <= CAPTURE;
            m1    <= lfsr_step(INIT1, POLY1);
            cap   <= cap_sof;
            c     <= N'(1);
            sdone <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                CAPTURE: begin
                    if (chip_vld_i) begin
                        m1  <= lfsr_step(m1, POLY1);
                        cap <= cap_shift;
                        c   <= c + 1'b1;
                        if (c == C_CAP_END) begin
                            // cap holds the m2 state at chip 0. Advance it N
                            // steps so pred lines up with chip N.
                            state <= TRACK;
                            pred  <= lfsr_adv_n(cap_shift, POLY2);
                            ref_s <= INIT2;
                            k     <= '0;
                            sdone <= 1'b0;
                            err   <= '0;
                        end
                    end
                end
                TRACK: begin
                    if (!sdone) begin
                        if (s_fin) begin
                            sdone   <= 1'b1;
                            shift_r <= s_shift_now;
                            nm_r    <= s_nm_now;
                        end else begin
                            ref_s <= lfsr_step(ref_s, POLY2);
                            k     <= k + 1'b1;
                        end
                    end
                    if (trk_chip) begin
                        m1   <= lfsr_step(m1, POLY1);
                        pred <= lfsr_step(pred, POLY2);
                        c    <= c + 1'b1;
                        err  <= err_now;
                    end
                    if (finish) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // AXI-Stream output register
    // ------------------------------------------------------------------
    logic [15:0] res;
    assign res = {1'b0, s_nm_now, err_now, 8'(s_shift_now)};

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (finish) begin
            if (!m_axis_tvalid || m_axis_tready) begin
                // The slot is free, or it is emptying this cycle: take the new result.
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= res;
            end else begin
                // Downstream is stalled: drop the new result and flag it.
                m_axis_tdata[15] <= 1'b1;
            end
        end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid    <= 1'b0;
            m_axis_tdata[15] <= 1'b0;
        end
    end

    assign m_axis_tlast = 1'b1;

endmodule

// File: tb/tb_gold_code_rx.sv
// Directed bench for gold_code_rx. A vector table sweeps every shift and covers
// the error and no-match cases. Hand-written sequences cover latency,
// back-to-back periods, overrun, abort and reset.
module tb_gold_code_rx;

    localparam int L = 31;
    localparam logic [4:0] P1 = 5'b00101;
    localparam logic [4:0] P2 = 5'b01111;
    localparam logic [4:0] I1 = 5'b00001;
    localparam logic [4:0] I2 = 5'b00001;

    logic        clkin = 1'b0;
    logic        rstn = 1'b0;
    logic        chip_i = 1'b0;
    logic        chip_vld_i = 1'b0;
    logic        sof_i = 1'b0;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tvalid;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tlast;

    always #5 clkin = ~clkin;

    gold_code_rx dut (
        .clkin         (clkin),
        .rstn          (rstn),
        .chip_i        (chip_i),
        .chip_vld_i    (chip_vld_i),
        .sof_i         (sof_i),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Beat monitor: records {tlast, tdata} for every handshake.
    logic [16:0] beats[$];
    always @(negedge clkin)
        if (rstn && m_axis_tvalid && m_axis_tready)
            beats.push_back({m_axis_tlast, m_axis_tdata});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [4:0] step(input logic [4:0] s, input logic [4:0] p);
        return {^(s & p), s[4:1]};
    endfunction

    // Generator model: drives nchips chips of a period with shift k. Before
    // each chip it inserts gap idle clocks. Bit j of inv flips chip j. If
    // hold=1, the last chip is left on the bus so the next call follows it
    // in the very next cycle.
    task automatic send_period(input int k, input logic [31:0] inv, input int gap,
                               input bit m1_only, input int nchips, input bit hold);
        logic [4:0] a, b;
        a = I1;
        b = I2;
        for (int i = 0; i < k; i++) b = step(b, P2);
        for (int j = 0; j < nchips; j++) begin
            for (int g = 0; g < gap; g++) begin
                @(posedge clkin); #1;
                chip_vld_i = 1'b0;
                sof_i      = 1'b0;
            end
            @(posedge clkin); #1;
            chip_vld_i = 1'b1;
            sof_i      = (j == 0);
            chip_i     = a[0] ^ (m1_only ? 1'b0 : b[0]) ^ inv[j];
            a = step(a, P1);
            b = step(b, P2);
        end
        if (!hold) begin
            @(posedge clkin); #1;
            chip_vld_i = 1'b0;
            sof_i      = 1'b0;
        end
    endtask

    task automatic wait_beat(input string name, output logic [16:0] b);
        int t;
        t = 0;
        b = '0;
        while (beats.size() == 0 && t < 200) begin
            @(negedge clkin);
            t++;
        end
        check({name, "_arrived"}, (beats.size() > 0) ? 1 : 0, 1);
        if (beats.size() > 0) b = beats.pop_front();
    endtask

    typedef struct {
        int          k;
        logic [31:0] inv;
        int          gap;
        bit          m1_only;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] b;
        vec_t v;

        // Expected results: shift k in [7:0], clean stream, so no flags.
        for (int k = 0; k < L; k++) begin
            v.k = k; v.inv = '0; v.gap = (k == 0) ? 0 : 2; v.m1_only = 0;
            v.exp = 16'(k);
            vecs.push_back(v);
        end
        v.k = 9; v.inv = (32'd1 << 10) | (32'd1 << 20); v.gap = 0; v.m1_only = 0;
        v.exp = 16'h0209;   // shift 9, two chip errors
        vecs.push_back(v);
        v.k = 0; v.inv = '0; v.gap = 1; v.m1_only = 1;
        v.exp = 16'h4000;   // captured state 0: no_match, shift 0, no errors
        vecs.push_back(v);

        // Reset state
        repeat (3) @(negedge clkin);
        check("rst_tvalid", 32'(m_axis_tvalid), 0);
        check("rst_tdata",  32'(m_axis_tdata), 0);
        check("rst_tlast",  32'(m_axis_tlast), 1);
        @(posedge clkin); #1;
        rstn = 1'b1;

        // Chips without a preceding sof are ignored
        for (int j = 0; j < 10; j++) begin
            @(posedge clkin); #1;
            chip_vld_i = 1'b1; sof_i = 1'b0; chip_i = j[0];
        end
        @(posedge clkin); #1;
        chip_vld_i = 1'b0;
        repeat (40) @(negedge clkin);
        check("nosof_no_beat", 32'(beats.size()), 0);

        // Latency: shift 0 with continuous chips gives tvalid one clock after the last chip
        send_period(0, '0, 0, 0, L, 0);
        @(negedge clkin);
        check("lat1_tvalid", 32'(m_axis_tvalid), 1);
        wait_beat("lat1", b);
        check("lat1_tdata", 32'(b[15:0]), 32'h0000);
        check("lat1_tlast", 32'(b[16]), 1);

        // Table sweep
        foreach (vecs[i]) begin
            beats.delete();
            send_period(vecs[i].k, vecs[i].inv, vecs[i].gap, vecs[i].m1_only, L, 0);
            wait_beat($sformatf("vec%0d", i), b);
            check($sformatf("vec%0d_tdata", i), 32'(b[15:0]), 32'(vecs[i].exp));
            check($sformatf("vec%0d_tlast", i), 32'(b[16]), 1);
            repeat (3) @(negedge clkin);
            check($sformatf("vec%0d_one_beat", i), 32'(beats.size()), 0);
            check($sformatf("vec%0d_tvalid_drop", i), 32'(m_axis_tvalid), 0);
        end

        // An error inside the capture window corrupts the recovered shift
        beats.delete();
        send_period(9, (32'd1 << 2) | (32'd1 << 10) | (32'd1 << 20), 0, 0, L, 0);
        wait_beat("capwin", b);
        check("capwin_shift_bad", ((b[7:0] != 8'd9) || b[14]) ? 1 : 0, 1);
        check("capwin_err_nonzero", (b[13:8] != 6'd0) ? 1 : 0, 1);

        // The next sof arrives in the cycle right after chip L-1
        beats.delete();
        send_period(1, '0, 0, 0, L, 1);
        send_period(2, '0, 0, 0, L, 0);
        wait_beat("b2b_a", b);
        check("b2b_a_tdata", 32'(b[15:0]), 32'h0001);
        wait_beat("b2b_b", b);
        check("b2b_b_tdata", 32'(b[15:0]), 32'h0002);

        // Overrun: tready low across two periods
        beats.delete();
        @(posedge clkin); #1;
        m_axis_tready = 1'b0;
        send_period(4, '0, 0, 0, L, 0);
        repeat (10) @(negedge clkin);
        check("ovr_first_tvalid", 32'(m_axis_tvalid), 1);
        check("ovr_first_tdata", 32'(m_axis_tdata), 32'h0004);
        send_period(5, '0, 0, 0, L, 0);
        repeat (10) @(negedge clkin);
        check("ovr_tvalid", 32'(m_axis_tvalid), 1);
        check("ovr_tdata", 32'(m_axis_tdata), 32'h8004);
        check("ovr_no_beat_yet", 32'(beats.size()), 0);
        @(posedge clkin); #1;
        m_axis_tready = 1'b1;
        @(negedge clkin);
        @(negedge clkin);
        check("ovr_tvalid_drop", 32'(m_axis_tvalid), 0);
        check("ovr_beat_count", 32'(beats.size()), 1);
        if (beats.size() > 0) begin
            b = beats.pop_front();
            check("ovr_beat_tdata", 32'(b[15:0]), 32'h8004);
        end

        // Abort: sof reasserted at chip 12, then a clean shift-6 period
        beats.delete();
        send_period(13, '0, 0, 0, 12, 1);
        send_period(6, '0, 0, 0, L, 0);
        wait_beat("abort", b);
        check("abort_tdata", 32'(b[15:0]), 32'h0006);
        repeat (40) @(negedge clkin);
        check("abort_one_beat", 32'(beats.size()), 0);

        // Reset mid-TRACK, with an earlier result still held
        beats.delete();
        @(posedge clkin); #1;
        m_axis_tready = 1'b0;
        send_period(7, '0, 0, 0, L, 0);
        repeat (5) @(negedge clkin);
        check("rstmid_held", 32'(m_axis_tvalid), 1);
        send_period(8, '0, 0, 0, 20, 1);
        @(negedge clkin);
        rstn = 1'b0;
        #1;
        check("rstmid_tvalid", 32'(m_axis_tvalid), 0);
        check("rstmid_tdata", 32'(m_axis_tdata), 0);
        chip_vld_i = 1'b0;
        sof_i = 1'b0;
        @(posedge clkin); #1;
        rstn = 1'b1;
        m_axis_tready = 1'b1;
        repeat (60) @(negedge clkin);
        check("rstmid_no_beat", 32'(beats.size()), 0);
        send_period(2, '0, 0, 0, L, 0);
        wait_beat("rstmid_recover", b);
        check("rstmid_recover_tdata", 32'(b[15:0]), 32'h0002);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
